// File: rtl/chunked_seq_adder.sv
// Sequential add/subtract unit: processes CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. start/busy/done handshake.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_IDX = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CMASK    = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: a request is taken on any rising edge where start=1 and the
    // unit is not busy (IDLE or DONE); done is a single-cycle result-valid pulse.
    logic [1:0]       state;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] acc;

    int               base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] acc_next;
    logic             c_msb;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        base     = int'(idx) * CHUNK;
        chunk_a  = CHUNK'(op_a >> base);
        chunk_b  = CHUNK'(op_b >> base);
        csum     = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
        acc_next = (acc & ~(CMASK << base)) | (WIDTH'(csum[CHUNK-1:0]) << base);
        // Carry into the MSB recovered from the MSB sum bit and both operand MSBs
        c_msb    = csum[CHUNK-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub | cin;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= csum[CHUNK];
                    if (idx == LAST_IDX) begin
                        sum   <= acc_next;
                        cout  <= csum[CHUNK];
                        ovf   <= c_msb ^ csum[CHUNK];
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: 16/4 main instance plus 4/1 and 4/4 instances
// swept exhaustively against an integer-arithmetic reference.
module tb_chunked_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, cin, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        start_s1, start_s4, cin4, sub4;
    logic [3:0]  a4, b4;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  sum1;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] exp_q[$];

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_seq_adder #(.WIDTH(4), .CHUNK(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_s1), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    chunked_seq_adder #(.WIDTH(4), .CHUNK(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_s4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    // Returns {ovf, cout, sum} with sum in the low w bits.
    function automatic logic [17:0] golden(int w, logic [15:0] ta, logic [15:0] tb,
                                           logic tc, logic ts);
        longint mask, half, av, bv, cv, full, sa, sb, st;
        logic [15:0] nb;
        logic [17:0] r;
        nb   = ~tb;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        av   = longint'(ta) & mask;
        bv   = ts ? (longint'(nb) & mask) : (longint'(tb) & mask);
        cv   = (ts || tc) ? 1 : 0;
        full = av + bv + cv;
        sa   = (av >= half) ? av - (mask + 1) : av;
        sb   = (bv >= half) ? bv - (mask + 1) : bv;
        st   = sa + sb + cv;
        r[15:0] = 16'(full & mask);
        r[16]   = 1'((full >>> w) & 1);
        r[17]   = (st > half - 1) || (st < -half);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Issues one operation on the main instance and returns what it produced.
    task automatic drive_op(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic ts,
                            output logic [17:0] obs, output int lat, output bit hs_ok);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat   = 1;
        hs_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) hs_ok = 1'b0;
            tick();
            lat++;
        end
        if (!done) lat = -1;
        if (busy) hs_ok = 1'b0;
        obs = {ovf, cout, sum};
        tick();
        if (done) hs_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1; start_s1 = 1'b1; start_s4 = 1'b1;
        a = 16'($urandom); b = 16'($urandom); a4 = 4'hF; b4 = 4'h3;
        tick();
        tick();
        n_checks++;
        if ({busy, done, ovf, cout, sum} !== 20'h0)
            $display("FAIL reset_main: got busy=%0b done=%0b ovf=%0b cout=%0b sum=%h, want all 0",
                     busy, done, ovf, cout, sum);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, ovf1, cout1, sum1, busy4, done4, ovf4, cout4, sum4} !== 16'h0)
            $display("FAIL reset_small: got s1=%b%b%b%b%h s4=%b%b%b%b%h, want all 0",
                     busy1, done1, ovf1, cout1, sum1, busy4, done4, ovf4, cout4, sum4);
        else n_pass++;
        start = 1'b0; start_s1 = 1'b0; start_s4 = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_start_ignored: got busy=%0b done=%0b, want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [17:0] obs;
        int lat;
        bit hs;
        drive_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, obs, lat, hs);
        n_checks++;
        if (lat !== 5) $display("FAIL basic_latency: got %0d, want 5", lat);
        else n_pass++;
        n_checks++;
        if (hs !== 1'b1) $display("FAIL basic_handshake: busy/done pattern wrong (got %0b, want 1)", hs);
        else n_pass++;
        n_checks++;
        if (obs !== {2'b00, 16'h2233})
            $display("FAIL basic_result: got %h, want %h", obs, {2'b00, 16'h2233});
        else n_pass++;
    endtask

    task automatic test_carry();
        logic [17:0] obs;
        int lat;
        bit hs;
        drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, obs, lat, hs);
        n_checks++;
        if (obs !== {2'b01, 16'h0000})
            $display("FAIL carry_ripple: got %h, want %h", obs, {2'b01, 16'h0000});
        else n_pass++;
        drive_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, obs, lat, hs);
        n_checks++;
        if (obs !== {2'b10, 16'h8000})
            $display("FAIL carry_ovf: got %h, want %h", obs, {2'b10, 16'h8000});
        else n_pass++;
    endtask

    task automatic test_sub();
        logic [17:0] obs;
        int lat;
        bit hs;
        drive_op(16'h0005, 16'h0007, 1'b1, 1'b1, obs, lat, hs);
        n_checks++;
        if (obs !== {2'b00, 16'hFFFE})
            $display("FAIL sub_borrow: got %h, want %h", obs, {2'b00, 16'hFFFE});
        else n_pass++;
        drive_op(16'h8000, 16'h0001, 1'b0, 1'b1, obs, lat, hs);
        n_checks++;
        if (obs !== {2'b11, 16'h7FFF})
            $display("FAIL sub_ovf: got %h, want %h", obs, {2'b11, 16'h7FFF});
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        logic [17:0] exp;
        int lat;
        exp = golden(16, 16'h3C5A, 16'h1111, 1'b1, 1'b0);
        a = 16'h3C5A; b = 16'h1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 5) $display("FAIL ignore_start_latency: got %0d, want 5", lat);
        else n_pass++;
        n_checks++;
        if ({ovf, cout, sum} !== exp)
            $display("FAIL ignore_start_result: got %h, want %h", {ovf, cout, sum}, exp);
        else n_pass++;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL ignore_start_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa[5];
        logic [15:0] ob[5];
        logic        os[5];
        logic [17:0] exp;
        int n;
        for (int i = 0; i < 5; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom); os[i] = 1'($urandom);
        end
        a = oa[0]; b = ob[0]; sub = os[0]; cin = 1'b0; start = 1'b1;
        tick();
        a = oa[1]; b = ob[1]; sub = os[1];
        n = 1;
        for (int i = 0; i < 4; i++) begin
            while (!done && n < 40) begin
                tick();
                n++;
            end
            exp = golden(16, oa[i], ob[i], 1'b0, os[i]);
            n_checks++;
            if (n !== 5) $display("FAIL b2b_interval_%0d: got %0d cycles, want 5", i, n);
            else n_pass++;
            n_checks++;
            if ({ovf, cout, sum} !== exp)
                $display("FAIL b2b_result_%0d: got %h, want %h", i, {ovf, cout, sum}, exp);
            else n_pass++;
            if (i == 3) start = 1'b0;
            tick();
            n = 1;
            n_checks++;
            if ({ovf, cout, sum} !== exp)
                $display("FAIL b2b_hold_%0d: got %h, want %h", i, {ovf, cout, sum}, exp);
            else n_pass++;
            if (i < 3) begin
                a = oa[i+2]; b = ob[i+2]; sub = os[i+2];
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, ovf, cout, sum} !== 20'h0)
            $display("FAIL reset_mid_run: got busy=%0b done=%0b ovf=%0b cout=%0b sum=%h, want all 0",
                     busy, done, ovf, cout, sum);
        else n_pass++;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL reset_mid_run_no_done: got activity=1, want 0");
        else n_pass++;
    endtask

    task automatic test_random();
        logic [17:0] obs, exp;
        logic [15:0] ta, tb;
        logic tc, ts;
        int lat;
        bit hs;
        for (int i = 0; i < 40; i++) begin
            ta = 16'($urandom); tb = 16'($urandom);
            tc = 1'($urandom); ts = 1'($urandom);
            if (i % 8 == 0) tb = ta;
            exp_q.push_back(golden(16, ta, tb, tc, ts));
            drive_op(ta, tb, tc, ts, obs, lat, hs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp || lat !== 5 || hs !== 1'b1)
                $display("FAIL random_%0d: a=%h b=%h cin=%0b sub=%0b got %h lat=%0d hs=%0b, want %h lat=5 hs=1",
                         i, ta, tb, tc, ts, obs, lat, hs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_exhaustive();
        logic [17:0] exp;
        int n;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int k = 0; k < 4; k++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = k[0]; sub4 = k[1];
                    exp = golden(4, 16'(ia), 16'(ib), k[0], k[1]);
                    start_s1 = 1'b1;
                    tick();
                    start_s1 = 1'b0;
                    n = 1;
                    while (!done1 && n < 20) begin
                        tick();
                        n++;
                    end
                    n_checks++;
                    if (n !== 5 || {ovf1, cout1, 12'h0, sum1} !== exp)
                        $display("FAIL exh_c1 a=%h b=%h cin=%0b sub=%0b: got lat=%0d %b%b_%h, want lat=5 %h",
                                 a4, b4, cin4, sub4, n, ovf1, cout1, sum1, exp);
                    else n_pass++;
                    start_s4 = 1'b1;
                    tick();
                    start_s4 = 1'b0;
                    n = 1;
                    while (!done4 && n < 20) begin
                        tick();
                        n++;
                    end
                    n_checks++;
                    if (n !== 2 || {ovf4, cout4, 12'h0, sum4} !== exp)
                        $display("FAIL exh_c4 a=%h b=%h cin=%0b sub=%0b: got lat=%0d %b%b_%h, want lat=2 %h",
                                 a4, b4, cin4, sub4, n, ovf4, cout4, sum4, exp);
                    else n_pass++;
                end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start_s1 = 1'b0; start_s4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
